ex_muldiv_sequencer: RTL and testbench

EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

---
 rtl/ex_muldiv_sequencer.sv | 127 ++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, 32 RUN cycles per operation, stalling the pipeline while it works.
module ex_muldiv_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        StartE,
    input  logic [1:0]  MulDivOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushE,
    output logic        BusyE,
    output logic        DoneE,
    output logic [31:0] ResultE
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] prod_q;
    logic [32:0] rem_q;

    logic        accept, div_zero, last_iter;
    logic [32:0] mul_sum, div_shift, div_diff, rem_next;
    logic [63:0] mul_next;
    logic [31:0] quo_next, final_result;
    logic        div_ge;

    assign accept    = (state_q == IDLE) && StartE && !FlushE;
    assign div_zero  = MulDivOpE[1] && (SrcBE == 32'd0);
    assign last_iter = (cnt_q == 5'd31);

    // NOTE: state register uses non-blocking assignment; the next-state logic lives in always_comb.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        BusyE   = 1'b0;
        DoneE   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    BusyE   = 1'b1;
                    state_d = div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                BusyE = 1'b1;
                if (FlushE)         state_d = IDLE;
                else if (last_iter) state_d = DONE;
            end
            DONE: begin
                DoneE   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One multiply step: add multiplicand into the high half when the current multiplier bit
    // is set, then shift the whole product right; the multiplier is consumed from prod_q[31:0].
    assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_q} : 33'd0);
    assign mul_next = {mul_sum, prod_q[31:1]};

    // One restoring-divide step: prod_q[31:0] holds the dividend shifting out at the top
    // while quotient bits shift in at the bottom.
    assign div_shift = {rem_q[31:0], prod_q[31]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = !div_diff[32];
    assign rem_next  = div_ge ? div_diff : div_shift;
    assign quo_next  = {prod_q[30:0], div_ge};

    always_comb begin
        case (op_q)
            OP_MUL:   final_result = mul_next[31:0];
            OP_MULHU: final_result = mul_next[63:32];
            OP_DIVU:  final_result = quo_next;
            default:  final_result = rem_next[31:0];
        endcase
    end

    // NOTE: all datapath registers take the asynchronous reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= 5'd0;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            prod_q  <= 64'd0;
            rem_q   <= 33'd0;
            ResultE <= 32'd0;
        end else if (accept) begin
            cnt_q  <= 5'd0;
            op_q   <= MulDivOpE;
            a_q    <= SrcAE;
            b_q    <= SrcBE;
            prod_q <= {32'd0, (MulDivOpE[1] ? SrcAE : SrcBE)};
            rem_q  <= 33'd0;
            if (div_zero)
                ResultE <= (MulDivOpE == OP_DIVU) ? 32'hFFFF_FFFF : SrcAE;
        end else if (state_q == RUN && !FlushE) begin
            if (!last_iter) cnt_q <= cnt_q + 5'd1;
            if (op_q[1]) begin
                prod_q <= {prod_q[63:32], quo_next};
                rem_q  <= rem_next;
            end else begin
                prod_q <= mul_next;
            end
            if (last_iter) ResultE <= final_result;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench: a cycle-level behavioural model (latency countdown plus plain
// arithmetic results) compared every cycle, plus directed vectors with literal results.
module tb_ex_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        StartE = 1'b0;
    logic [1:0]  MulDivOpE = 2'b00;
    logic [31:0] SrcAE = 32'd0;
    logic [31:0] SrcBE = 32'd0;
    logic        FlushE = 1'b0;
    logic        BusyE, DoneE;
    logic [31:0] ResultE;

    int checks = 0;
    int failures = 0;

    ex_muldiv_sequencer dut (
        .clk      (clk),
        .resetn   (resetn),
        .StartE   (StartE),
        .MulDivOpE(MulDivOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .FlushE   (FlushE),
        .BusyE    (BusyE),
        .DoneE    (DoneE),
        .ResultE  (ResultE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Model: m_left counts remaining RUN cycles, m_done marks the completion cycle.
    int          m_left;
    logic        m_done;
    logic [31:0] m_res, m_pend;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 32'd0;
            m_pend <= 32'd0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (FlushE) m_left <= 0;
            else if (m_left == 1) begin
                m_left <= 0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end else m_left <= m_left - 1;
        end else if (StartE && !FlushE) begin
            if (MulDivOpE[1] && SrcBE == 32'd0) begin
                m_done <= 1'b1;
                m_res  <= ref_result(MulDivOpE, SrcAE, SrcBE);
            end else begin
                m_left <= 32;
                m_pend <= ref_result(MulDivOpE, SrcAE, SrcBE);
            end
        end
    end

    logic exp_busy;
    assign exp_busy = (m_left > 0) || (!m_done && StartE && !FlushE);

    always @(negedge clk) begin
        #2;
        check("model_busy", {31'd0, BusyE}, {31'd0, exp_busy});
        check("model_done", {31'd0, DoneE}, {31'd0, m_done});
        check("model_result", ResultE, m_res);
    end

    // Issue one instruction and hold it in EX until DoneE; checks busy length and literal result.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int exp_busy_cycles,
                         input bit flush_at_done);
        int busy_cnt;
        int n;
        busy_cnt = 0;
        n = 0;
        @(negedge clk);
        StartE = 1'b1;
        MulDivOpE = op;
        SrcAE = a;
        SrcBE = b;
        FlushE = 1'b0;
        forever begin
            #2;
            if (DoneE) break;
            if (BusyE) busy_cnt++;
            n++;
            if (n > 40) break;
            @(negedge clk);
        end
        check({name, "_done_seen"}, {31'd0, DoneE}, 32'd1);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy_cycles);
        check({name, "_result"}, ResultE, lit);
        if (flush_at_done) FlushE = 1'b1;
    endtask

    task automatic go_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            StartE = 1'b0;
            FlushE = 1'b0;
        end
    endtask

    initial begin
        #12;
        #1;
        check("reset_busy", {31'd0, BusyE}, 32'd0);
        check("reset_done", {31'd0, DoneE}, 32'd0);
        check("reset_result", ResultE, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        go_idle(2);

        do_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 33, 1'b0);
        go_idle(2);
        do_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        do_op("mul_max_b2b", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0);
        go_idle(1);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        go_idle(1);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        go_idle(1);
        do_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        go_idle(1);
        do_op("remu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 1'b0);
        go_idle(1);
        do_op("mul_shift", 2'b00, 32'h1234_5678, 32'h10, 32'h2345_6780, 33, 1'b0);
        go_idle(1);
        do_op("divu_max_1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
        go_idle(1);
        do_op("remu_small", 2'b11, 32'd5, 32'd9, 32'd5, 33, 1'b0);
        go_idle(1);

        // Flush in IDLE blocks the accept.
        @(negedge clk);
        StartE = 1'b1; MulDivOpE = 2'b00; SrcAE = 32'd2; SrcBE = 32'd2; FlushE = 1'b1;
        #2 check("idle_flush_busy", {31'd0, BusyE}, 32'd0);
        go_idle(3);
        check("idle_flush_result", ResultE, 32'd5);

        // Flush in the 10th RUN cycle aborts without a completion.
        @(negedge clk);
        StartE = 1'b1; MulDivOpE = 2'b00; SrcAE = 32'd9; SrcBE = 32'd9; FlushE = 1'b0;
        repeat (10) @(negedge clk);
        StartE = 1'b0; FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        #2 check("abort_busy", {31'd0, BusyE}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2 check("abort_no_done", {31'd0, DoneE}, 32'd0);
        end
        check("abort_result_kept", ResultE, 32'd5);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        StartE = 1'b1; MulDivOpE = 2'b00; SrcAE = 32'd7; SrcBE = 32'd6;
        repeat (5) @(negedge clk);
        #3;
        resetn = 1'b0;
        StartE = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, BusyE}, 32'd0);
        check("rst_mid_done", {31'd0, DoneE}, 32'd0);
        check("rst_mid_result", ResultE, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        go_idle(2);
        do_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F, 33, 1'b0);
        go_idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
